// File: rtl/accumulator_program_counter.sv
// Datapath core: a free-running accumulator and a program counter that share one clock
// and one synchronous, active-high reset. The accumulator adds data_in on every edge.
// The PC either steps by PC_STEP or loads jump_addr.
module accumulator_program_counter #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned PC_STEP  = 1,
   parameter int unsigned PC_RESET = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [DATA_W-1:0] acc,
   output logic [ADDR_W-1:0] pc,
   output logic              acc_carry,
   output logic              acc_zero
);

   // Parameters resized to the PC width so the step and reset value wrap cleanly.
   localparam logic [ADDR_W-1:0] PcStep  = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(PC_RESET);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              carry_q, carry_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W:0]   sum;

   // One extra bit captures the carry-out of the accumulate.
   assign sum = {1'b0, acc_q} + {1'b0, data_in};

   // Next-state logic: the accumulator and the PC are independent of each other.
   always_comb begin
      acc_d   = sum[DATA_W-1:0];
      carry_d = sum[DATA_W];
      pc_d    = pc_q + PcStep;
      if (jump) begin
         pc_d = jump_addr;
      end
   end

   // State registers. Reset takes priority over jump and accumulate.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         pc_q    <= PcReset;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
         pc_q    <= pc_d;
      end
   end

   assign acc       = acc_q;
   assign acc_carry = carry_q;
   assign pc        = pc_q;
   // Only acc_zero is combinational; it follows acc without a register stage.
   assign acc_zero  = (acc_q == '0);

endmodule

// File: tb/tb_accumulator_program_counter.sv
// Directed, table-driven bench for accumulator_program_counter.
module tb_accumulator_program_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        jump;
   logic [15:0] jump_addr;
   logic [15:0] acc;
   logic [15:0] pc;
   logic        acc_carry;
   logic        acc_zero;

   int checks = 0;
   int fails  = 0;

   accumulator_program_counter #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .PC_STEP (1),
      .PC_RESET(0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .jump     (jump),
      .jump_addr(jump_addr),
      .acc      (acc),
      .pc       (pc),
      .acc_carry(acc_carry),
      .acc_zero (acc_zero)
   );

   always #5 clk = ~clk;

   // One row: inputs applied before an edge, expected outputs after it.
   typedef struct {
      logic        rst;
      logic [15:0] din;
      logic        jmp;
      logic [15:0] jaddr;
      logic [15:0] e_acc;
      logic [15:0] e_pc;
      logic        e_carry;
      logic        e_zero;
   } vec_t;

   localparam int NumVec = 18;
   vec_t vecs [NumVec];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [15:0] d, input logic j, input logic [15:0] ja);
      reset     = r;
      data_in   = d;
      jump      = j;
      jump_addr = ja;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e_acc, input logic [15:0] e_pc,
                          input logic e_carry, input logic e_zero);
      chk({tag, " acc"}, acc, e_acc);
      chk({tag, " pc"}, pc, e_pc);
      chk({tag, " acc_carry"}, {15'd0, acc_carry}, {15'd0, e_carry});
      chk({tag, " acc_zero"}, {15'd0, acc_zero}, {15'd0, e_zero});
   endtask

   initial begin
      //           rst   din       jmp   jaddr     acc       pc        c     z
      vecs[0]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1234, 16'h0003, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 16'h1234, 1'b0, 16'h0000, 16'h2468, 16'h0004, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h5678, 16'h2468, 16'h5678, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h5678, 16'h2468, 16'h5678, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h5678, 16'h2468, 16'h5679, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h2468, 16'h567A, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 16'h8000, 1'b1, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 16'h8000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vecs[16] = '{1'b1, 16'hDEF0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 16'h0005, 1'b1, 16'h0010, 16'h0005, 16'h0010, 1'b0, 1'b0};

      reset     = 1'b1;
      data_in   = '0;
      jump      = 1'b0;
      jump_addr = '0;

      for (int i = 0; i < NumVec; i++) begin
         step(vecs[i].rst, vecs[i].din, vecs[i].jmp, vecs[i].jaddr);
         chk_all($sformatf("v%0d", i), vecs[i].e_acc, vecs[i].e_pc, vecs[i].e_carry,
                 vecs[i].e_zero);
      end

      // Overflow to exactly zero, then a mid-operation reset clears a pending carry.
      step(1'b0, 16'hFFFB, 1'b0, 16'h0000);
      chk_all("seq_ovf", 16'h0000, 16'h0011, 1'b1, 1'b1);
      step(1'b1, 16'h0001, 1'b0, 16'h0000);
      chk_all("seq_rst", 16'h0000, 16'h0000, 1'b0, 1'b1);

      // Holding jump high keeps reloading while data_in keeps accumulating.
      step(1'b0, 16'h00FF, 1'b1, 16'hABCD);
      step(1'b0, 16'h0001, 1'b1, 16'hABCD);
      chk_all("seq_hold", 16'h0100, 16'hABCD, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
